// File: rtl/tc_kloop_sequencer.sv
// rtl/tc_kloop_sequencer.sv - K-loop sequencer driving one tensor core tile engine per command
// Accumulator feeds back as the next step's C, so tile steps are strictly serial.

module tc_kloop_sequencer #(
    parameter int VL         = 8,
    parameter int AB_W       = 576,
    parameter int C_W        = 512,
    parameter int KCNT_W     = 4,
    parameter int DEPTH_WARP = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [KCNT_W-1:0]     cmd_ktiles_i,
    input  logic [C_W-1:0]        cmd_c_i,
    input  logic [2:0]            cmd_rm_i,
    input  logic [4:0]            cmd_type_ab_i,
    input  logic [2:0]            cmd_type_ab_sub_i,
    input  logic [4:0]            cmd_type_cd_i,
    input  logic [DEPTH_WARP-1:0] cmd_warpid_i,
    input  logic [7:0]            cmd_reg_idxw_i,

    output logic [KCNT_W-1:0]     opnd_k_o,
    input  logic                  opnd_valid_i,
    input  logic [AB_W-1:0]       opnd_a_i,
    input  logic [AB_W-1:0]       opnd_b_i,
    output logic                  opnd_ready_o,

    output logic                  tc_in_valid_o,
    input  logic                  tc_in_ready_i,
    output logic [AB_W-1:0]       tc_a_o,
    output logic [AB_W-1:0]       tc_b_o,
    output logic [C_W-1:0]        tc_c_o,
    output logic [2:0]            tc_rm_o,
    output logic [4:0]            tc_type_ab_o,
    output logic [2:0]            tc_type_ab_sub_o,
    output logic [4:0]            tc_type_cd_o,
    input  logic                  tc_out_valid_i,
    output logic                  tc_out_ready_o,
    input  logic [C_W-1:0]        tc_result_i,
    input  logic [VL*5-1:0]       tc_fflags_i,

    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [C_W-1:0]        res_data_o,
    output logic [VL*5-1:0]       res_fflags_o,
    output logic [DEPTH_WARP-1:0] res_warpid_o,
    output logic [7:0]            res_reg_idxw_o,

    output logic                  busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state, state_nx;
    logic [KCNT_W-1:0]     k_cnt;
    logic [KCNT_W-1:0]     ktiles_q;
    logic [C_W-1:0]        acc;
    logic [VL*5-1:0]       fflags_acc;
    logic [2:0]            rm_q;
    logic [4:0]            type_ab_q;
    logic [2:0]            type_ab_sub_q;
    logic [4:0]            type_cd_q;
    logic [DEPTH_WARP-1:0] warpid_q;
    logic [7:0]            reg_idxw_q;
    logic                  last_step;

    assign last_step = (k_cnt == ktiles_q - KCNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cmd_ready_o    = 1'b0;
        tc_in_valid_o  = 1'b0;
        opnd_ready_o   = 1'b0;
        tc_out_ready_o = 1'b0;
        res_valid_o    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_nx = (cmd_ktiles_i != '0) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                // Operand availability gates the issue directly; the slice is consumed only on a real fire.
                tc_in_valid_o = opnd_valid_i;
                opnd_ready_o  = opnd_valid_i & tc_in_ready_i;
                if (opnd_valid_i && tc_in_ready_i) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                tc_out_ready_o = 1'b1;
                if (tc_out_valid_i) begin
                    state_nx = last_step ? S_RESP : S_ISSUE;
                end
            end
            S_RESP: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt         <= '0;
            ktiles_q      <= '0;
            acc           <= '0;
            fflags_acc    <= '0;
            rm_q          <= '0;
            type_ab_q     <= '0;
            type_ab_sub_q <= '0;
            type_cd_q     <= '0;
            warpid_q      <= '0;
            reg_idxw_q    <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid_i) begin
                k_cnt         <= '0;
                ktiles_q      <= cmd_ktiles_i;
                acc           <= cmd_c_i;
                fflags_acc    <= '0;
                rm_q          <= cmd_rm_i;
                type_ab_q     <= cmd_type_ab_i;
                type_ab_sub_q <= cmd_type_ab_sub_i;
                type_cd_q     <= cmd_type_cd_i;
                warpid_q      <= cmd_warpid_i;
                reg_idxw_q    <= cmd_reg_idxw_i;
            end
            if (state == S_WAIT && tc_out_valid_i) begin
                acc        <= tc_result_i;
                fflags_acc <= fflags_acc | tc_fflags_i;
                if (!last_step) begin
                    k_cnt <= k_cnt + KCNT_W'(1);
                end
            end
        end
    end

    assign opnd_k_o         = k_cnt;
    assign tc_a_o           = opnd_a_i;
    assign tc_b_o           = opnd_b_i;
    assign tc_c_o           = acc;
    assign tc_rm_o          = rm_q;
    assign tc_type_ab_o     = type_ab_q;
    assign tc_type_ab_sub_o = type_ab_sub_q;
    assign tc_type_cd_o     = type_cd_q;
    assign res_data_o       = acc;
    assign res_fflags_o     = fflags_acc;
    assign res_warpid_o     = warpid_q;
    assign res_reg_idxw_o   = reg_idxw_q;
    assign busy_o           = (state != S_IDLE);

endmodule

// File: tb/tb_tc_kloop_sequencer.sv
// tb/tb_tc_kloop_sequencer.sv - scoreboard bench for tc_kloop_sequencer

module tb_tc_kloop_sequencer;

    localparam int VL     = 8;
    localparam int AB_W   = 576;
    localparam int C_W    = 512;
    localparam int KCNT_W = 4;
    localparam int DW     = 3;
    localparam int L      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [KCNT_W-1:0] cmd_ktiles_i = '0;
    logic [C_W-1:0]    cmd_c_i = '0;
    logic [2:0]        cmd_rm_i = '0;
    logic [4:0]        cmd_type_ab_i = '0;
    logic [2:0]        cmd_type_ab_sub_i = '0;
    logic [4:0]        cmd_type_cd_i = '0;
    logic [DW-1:0]     cmd_warpid_i = '0;
    logic [7:0]        cmd_reg_idxw_i = '0;
    logic [KCNT_W-1:0] opnd_k_o;
    logic              opnd_valid_i = 1'b1;
    logic [AB_W-1:0]   opnd_a_i = '0;
    logic [AB_W-1:0]   opnd_b_i = '0;
    logic              opnd_ready_o;
    logic              tc_in_valid_o;
    logic              tc_in_ready_i = 1'b1;
    logic [AB_W-1:0]   tc_a_o, tc_b_o;
    logic [C_W-1:0]    tc_c_o;
    logic [2:0]        tc_rm_o;
    logic [4:0]        tc_type_ab_o;
    logic [2:0]        tc_type_ab_sub_o;
    logic [4:0]        tc_type_cd_o;
    logic              tc_out_valid_i = 1'b0;
    logic              tc_out_ready_o;
    logic [C_W-1:0]    tc_result_i = '0;
    logic [VL*5-1:0]   tc_fflags_i = '0;
    logic              res_valid_o;
    logic              res_ready_i = 1'b1;
    logic [C_W-1:0]    res_data_o;
    logic [VL*5-1:0]   res_fflags_o;
    logic [DW-1:0]     res_warpid_o;
    logic [7:0]        res_reg_idxw_o;
    logic              busy_o;

    tc_kloop_sequencer #(
        .VL(VL), .AB_W(AB_W), .C_W(C_W), .KCNT_W(KCNT_W), .DEPTH_WARP(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_ktiles_i(cmd_ktiles_i),
        .cmd_c_i(cmd_c_i), .cmd_rm_i(cmd_rm_i), .cmd_type_ab_i(cmd_type_ab_i),
        .cmd_type_ab_sub_i(cmd_type_ab_sub_i), .cmd_type_cd_i(cmd_type_cd_i),
        .cmd_warpid_i(cmd_warpid_i), .cmd_reg_idxw_i(cmd_reg_idxw_i),
        .opnd_k_o(opnd_k_o), .opnd_valid_i(opnd_valid_i), .opnd_a_i(opnd_a_i),
        .opnd_b_i(opnd_b_i), .opnd_ready_o(opnd_ready_o),
        .tc_in_valid_o(tc_in_valid_o), .tc_in_ready_i(tc_in_ready_i),
        .tc_a_o(tc_a_o), .tc_b_o(tc_b_o), .tc_c_o(tc_c_o), .tc_rm_o(tc_rm_o),
        .tc_type_ab_o(tc_type_ab_o), .tc_type_ab_sub_o(tc_type_ab_sub_o),
        .tc_type_cd_o(tc_type_cd_o), .tc_out_valid_i(tc_out_valid_i),
        .tc_out_ready_o(tc_out_ready_o), .tc_result_i(tc_result_i), .tc_fflags_i(tc_fflags_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_fflags_o(res_fflags_o), .res_warpid_o(res_warpid_o),
        .res_reg_idxw_o(res_reg_idxw_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [KCNT_W-1:0] k;
        logic [C_W-1:0]    c;
    } iss_t;

    typedef struct {
        logic [C_W-1:0]  d;
        logic [VL*5-1:0] ff;
        logic [DW-1:0]   w;
        logic [7:0]      r;
        int              acc_cyc;
        int              lat;
    } res_t;

    iss_t iss_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   opnd_stall = 0;
    int   in_stall = 0;
    int   res_stall = 0;
    logic [15:0] g_fmt = '0;

    function automatic logic [AB_W-1:0] pat_a(input logic [KCNT_W-1:0] k);
        return {{(AB_W-16){1'b0}}, 8'hA0, 4'h0, k};
    endfunction

    function automatic logic [AB_W-1:0] pat_b(input logic [KCNT_W-1:0] k);
        return {{(AB_W-16){1'b0}}, 8'hB0, 4'h0, k};
    endfunction

    // Flag pattern of the tensor core model, keyed by the incoming C tile.
    function automatic logic [VL*5-1:0] ff_of(input logic [C_W-1:0] c);
        if (c == C_W'(100)) return 40'h0000000404;
        if (c == C_W'(101)) return 40'h0000004000;
        return '0;
    endfunction

    task automatic chk(input string name, input logic [C_W-1:0] act, input logic [C_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Operand source, stall injection and tensor core model (result = C + 1 after L cycles).
    initial begin
        logic [C_W-1:0] cap_c;
        logic           issue_f, out_f;
        int             tc_due;
        tc_due = -1;
        cap_c  = '0;
        forever begin
            @(negedge clk);
            issue_f = tc_in_valid_o & tc_in_ready_i;
            out_f   = tc_out_valid_i & tc_out_ready_o;
            if (issue_f) begin
                cap_c  = tc_c_o;
                tc_due = cyc + L;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                tc_out_valid_i = 1'b0;
                tc_due = -1;
            end else begin
                if (out_f) tc_out_valid_i = 1'b0;
                if (cyc == tc_due) begin
                    tc_out_valid_i = 1'b1;
                    tc_result_i    = cap_c + C_W'(1);
                    tc_fflags_i    = ff_of(cap_c);
                    tc_due         = -1;
                end
            end
            if (opnd_stall > 0) begin
                opnd_valid_i  = 1'b0;
                tc_in_ready_i = 1'b1;
                opnd_stall--;
            end else begin
                opnd_valid_i  = 1'b1;
                tc_in_ready_i = (in_stall == 0);
                if (in_stall > 0) in_stall--;
            end
            res_ready_i = (res_stall == 0);
            if (res_stall > 0 && res_valid_o) res_stall--;
            opnd_a_i = pat_a(opnd_k_o);
            opnd_b_i = pat_b(opnd_k_o);
        end
    end

    // Monitor: pops the scoreboard on every issue fire and every result handshake.
    initial begin
        iss_t            ie;
        res_t            re;
        logic            prev_rv, prev_rr;
        logic [C_W-1:0]  prev_d;
        logic [63:0]     prev_tag;
        int              rise_cyc;
        prev_rv = 1'b0; prev_rr = 1'b1; prev_d = '0; prev_tag = '0; rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (tc_in_valid_o && tc_in_ready_i) begin
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: k=%0d c=%0h, none expected", opnd_k_o, tc_c_o);
                end else begin
                    ie = iss_q.pop_front();
                    chk("issue_k", C_W'(opnd_k_o), C_W'(ie.k));
                    chk("issue_c", tc_c_o, ie.c);
                    chk("issue_a", C_W'(tc_a_o), C_W'(pat_a(ie.k)));
                    chk("issue_b", C_W'(tc_b_o), C_W'(pat_b(ie.k)));
                    chk("issue_fmt", C_W'({tc_rm_o, tc_type_ab_o, tc_type_ab_sub_o, tc_type_cd_o}), C_W'(g_fmt));
                    chk("opnd_ready", C_W'(opnd_ready_o), C_W'(1));
                end
            end
            if (res_valid_o && !prev_rv) rise_cyc = cyc;
            if (res_valid_o && prev_rv && !prev_rr) begin
                chk("res_stable_data", res_data_o, prev_d);
                chk("res_stable_tag", C_W'({res_fflags_o, res_warpid_o, res_reg_idxw_o}), C_W'(prev_tag));
            end
            if (res_valid_o && res_ready_i) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: data=%0h, none expected", res_data_o);
                end else begin
                    re = res_q.pop_front();
                    chk("res_data", res_data_o, re.d);
                    chk("res_fflags", C_W'(res_fflags_o), C_W'(re.ff));
                    chk("res_tags", C_W'({res_warpid_o, res_reg_idxw_o}), C_W'({re.w, re.r}));
                    if (re.lat >= 0) chk("res_latency", C_W'(rise_cyc - re.acc_cyc), C_W'(re.lat - 1));
                end
            end
            prev_rv  = res_valid_o;
            prev_rr  = res_ready_i;
            prev_d   = res_data_o;
            prev_tag = 64'({res_fflags_o, res_warpid_o, res_reg_idxw_o});
        end
    end

    task automatic push_iss(input logic [KCNT_W-1:0] k, input logic [C_W-1:0] c);
        iss_t e;
        e.k = k; e.c = c;
        iss_q.push_back(e);
    endtask

    task automatic send(input logic [KCNT_W-1:0] kt, input logic [C_W-1:0] c,
                        input logic [DW-1:0] w, input logic [7:0] r,
                        input logic [C_W-1:0] exp_d, input logic [VL*5-1:0] exp_ff, input int lat);
        res_t e;
        bit   ok;
        @(posedge clk);
        #1;
        cmd_valid_i       = 1'b1;
        cmd_ktiles_i      = kt;
        cmd_c_i           = c;
        {cmd_rm_i, cmd_type_ab_i, cmd_type_ab_sub_i, cmd_type_cd_i} = g_fmt;
        cmd_warpid_i      = w;
        cmd_reg_idxw_i    = r;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready_o=%0b required 1", cmd_ready_o);
        end
        e.d = exp_d; e.ff = exp_ff; e.w = w; e.r = r; e.acc_cyc = cyc + 1; e.lat = lat;
        res_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (res_q.size() == 0 && iss_q.size() == 0 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: %0d results and %0d issues outstanding, required 0", name, res_q.size(), iss_q.size());
            res_q.delete();
            iss_q.delete();
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_busy"}, C_W'(busy_o), C_W'(0));
        chk({name, "_res_valid"}, C_W'(res_valid_o), C_W'(0));
        chk({name, "_tc_in_valid"}, C_W'(tc_in_valid_o), C_W'(0));
        chk({name, "_cmd_ready"}, C_W'(cmd_ready_o), C_W'(1));
        chk({name, "_tc_out_ready"}, C_W'(tc_out_ready_o), C_W'(0));
    endtask

    initial begin
        bit ok;
        repeat (2) @(negedge clk);
        chk_idle_outputs("por");
        chk("por_res_data", res_data_o, C_W'(0));
        chk("por_k", C_W'(opnd_k_o), C_W'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T2: single step, result C+1 = 1, res_valid at t+6
        g_fmt = {3'd1, 5'd2, 3'd3, 5'd4};
        push_iss(4'd0, C_W'(0));
        send(4'd1, C_W'(0), 3'd2, 8'h11, C_W'(1), '0, 2 + L);
        wait_done("t2");

        // T3: three steps, C chain 5,6,7 -> 8, res_valid at t+1+3*(L+1)
        g_fmt = {3'd4, 5'd9, 3'd1, 5'd7};
        push_iss(4'd0, C_W'(5));
        push_iss(4'd1, C_W'(6));
        push_iss(4'd2, C_W'(7));
        send(4'd3, C_W'(5), 3'd5, 8'h22, C_W'(8), '0, 1 + 3 * (L + 1));
        wait_done("t3");

        // T4: zero steps, C passes through one cycle after accept
        send(4'd0, C_W'(16'hABCD), 3'd7, 8'hFE, C_W'(16'hABCD), '0, 1);
        wait_done("t4");

        // T5: operand, issue and writeback stalls
        push_iss(4'd0, C_W'(20));
        push_iss(4'd1, C_W'(21));
        opnd_stall = 5;
        in_stall   = 2;
        res_stall  = 4;
        send(4'd2, C_W'(20), 3'd1, 8'h33, C_W'(22), '0, -1);
        wait_done("t5");

        // T6: fflags OR across steps, then back-to-back command with cleared fflags
        push_iss(4'd0, C_W'(100));
        push_iss(4'd1, C_W'(101));
        push_iss(4'd0, C_W'(200));
        push_iss(4'd1, C_W'(201));
        send(4'd2, C_W'(100), 3'd3, 8'h44, C_W'(102), 40'h0000004404, -1);
        send(4'd2, C_W'(200), 3'd4, 8'h55, C_W'(202), '0, -1);
        wait_done("t6");

        // T1: async reset while waiting on the tensor core aborts the command
        push_iss(4'd0, C_W'(50));
        send(4'd2, C_W'(50), 3'd6, 8'h66, C_W'(52), '0, -1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tc_out_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t1_reached_wait", C_W'(ok), C_W'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_outputs("t1_rst");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_q.delete();
        iss_q.delete();
        repeat (20) @(negedge clk);
        chk_idle_outputs("t1_after");
        chk("t1_acc_cleared", res_data_o, C_W'(0));

        // Sequencer still usable after the abort
        g_fmt = {3'd2, 5'd3, 3'd4, 5'd5};
        push_iss(4'd0, C_W'(9));
        send(4'd1, C_W'(9), 3'd0, 8'h77, C_W'(10), '0, 2 + L);
        wait_done("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
